// File: rtl/simple_discriminator_if.sv
// Port bundle for simple_discriminator: sample handshake, score output and the
// three synchronous weight/bias ROM ports (data arrives one cycle after the address).
interface simple_discriminator_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8
);
  logic [9*DATA_WIDTH-1:0] sample_in;
  logic                    valid_in;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   score;
  logic                    valid_out;
  logic                    done;
  logic [4:0]              w1_addr;
  logic [WEIGHT_WIDTH-1:0] w1_data;
  logic [1:0]              b1_addr;
  logic [DATA_WIDTH-1:0]   b1_data;
  logic [1:0]              w2_addr;
  logic [WEIGHT_WIDTH-1:0] w2_data;
  logic [DATA_WIDTH-1:0]   b2_data;

  modport slave (
    input  sample_in, valid_in, w1_data, b1_data, w2_data, b2_data,
    output in_ready, score, valid_out, done, w1_addr, b1_addr, w2_addr
  );

  modport master (
    output sample_in, valid_in, w1_data, b1_data, w2_data, b2_data,
    input  in_ready, score, valid_out, done, w1_addr, b1_addr, w2_addr
  );
endinterface

// File: rtl/simple_discriminator.sv
// Time-multiplexed 9->3->1 MLP discriminator with a single MAC and external ROMs.
// Define SIMPLE_DISC_SIGMOID_EN for a piecewise-linear sigmoid score instead of the raw logit.
module simple_discriminator #(
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 32
) (
  input logic                    clk,
  input logic                    rst,
  simple_discriminator_if.slave  bus
);
  localparam int ProdWidth = DATA_WIDTH + WEIGHT_WIDTH;
  localparam logic signed [ACC_WIDTH:0] SatMax =
    (ACC_WIDTH+1)'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SatMin = ~SatMax;

  typedef enum logic [2:0] {StIdle, StL1Mac, StL1Act, StL2Mac, StL2Act, StDone} state_e;

  state_e                        state_q, state_d;
  logic [3:0]                    cnt_q, cnt_d;
  logic [1:0]                    nrn_q, nrn_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]  x_q [9];
  logic signed [DATA_WIDTH-1:0]  x_d [9];
  logic signed [DATA_WIDTH-1:0]  h_q [3];
  logic signed [DATA_WIDTH-1:0]  h_d [3];
  logic [DATA_WIDTH-1:0]         score_q, score_d;

  logic [3:0]                    mac_idx;
  logic signed [DATA_WIDTH-1:0]  mac_a;
  logic signed [WEIGHT_WIDTH-1:0] mac_b;
  logic signed [ProdWidth-1:0]   prod;

  function automatic logic signed [DATA_WIDTH-1:0] shift_bias_sat(
    input logic signed [ACC_WIDTH-1:0]  acc,
    input logic signed [DATA_WIDTH-1:0] bias
  );
    logic signed [ACC_WIDTH:0] s;
    s = (ACC_WIDTH+1)'(acc);
    s = s >>> 7;
    s = s + (ACC_WIDTH+1)'(bias);
    if (s > SatMax) s = SatMax;
    else if (s < SatMin) s = SatMin;
    return s[DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] leaky(input logic signed [DATA_WIDTH-1:0] r);
    return r[DATA_WIDTH-1] ? (r >>> 3) : r;
  endfunction

`ifdef SIMPLE_DISC_SIGMOID_EN
  localparam logic signed [DATA_WIDTH:0] SigMid = (DATA_WIDTH+1)'(128);
  localparam logic signed [DATA_WIDTH:0] SigTop = (DATA_WIDTH+1)'(256);

  // 128 + logit/4, clamped to [0, 256]: 0.0..1.0 in Q8.8
  function automatic logic [DATA_WIDTH-1:0] out_fn(input logic signed [DATA_WIDTH-1:0] logit);
    logic signed [DATA_WIDTH:0] t;
    t = (DATA_WIDTH+1)'(logit);
    t = t >>> 2;
    t = t + SigMid;
    if (t[DATA_WIDTH]) return '0;
    if (t > SigTop) return SigTop[DATA_WIDTH-1:0];
    return t[DATA_WIDTH-1:0];
  endfunction
`else
  function automatic logic [DATA_WIDTH-1:0] out_fn(input logic signed [DATA_WIDTH-1:0] logit);
    return logit;
  endfunction
`endif

  // ROM data lags the address by a cycle, so count n consumes operand n-1.
  always_comb begin
    mac_idx = cnt_q - 4'd1;
    mac_a   = '0;
    mac_b   = '0;
    if (state_q == StL1Mac && cnt_q != 4'd0) begin
      mac_a = x_q[mac_idx];
      mac_b = bus.w1_data;
    end else if (state_q == StL2Mac && cnt_q != 4'd0) begin
      mac_a = h_q[mac_idx[1:0]];
      mac_b = bus.w2_data;
    end
    prod = $signed(ProdWidth'(mac_a)) * $signed(ProdWidth'(mac_b));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nrn_d   = nrn_q;
    acc_d   = acc_q;
    x_d     = x_q;
    h_d     = h_q;
    score_d = score_q;
    unique case (state_q)
      StIdle: begin
        if (bus.valid_in) begin
          for (int k = 0; k < 9; k++) x_d[k] = bus.sample_in[DATA_WIDTH*k +: DATA_WIDTH];
          acc_d   = '0;
          cnt_d   = '0;
          nrn_d   = '0;
          state_d = StL1Mac;
        end
      end
      StL1Mac: begin
        acc_d = acc_q + ACC_WIDTH'(prod);
        if (cnt_q == 4'd9) begin
          cnt_d   = '0;
          state_d = StL1Act;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StL1Act: begin
        h_d[nrn_q] = leaky(shift_bias_sat(acc_q, bus.b1_data));
        acc_d      = '0;
        if (nrn_q == 2'd2) begin
          nrn_d   = '0;
          state_d = StL2Mac;
        end else begin
          nrn_d   = nrn_q + 2'd1;
          state_d = StL1Mac;
        end
      end
      StL2Mac: begin
        acc_d = acc_q + ACC_WIDTH'(prod);
        if (cnt_q == 4'd3) begin
          cnt_d   = '0;
          state_d = StL2Act;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StL2Act: begin
        score_d = out_fn(shift_bias_sat(acc_q, bus.b2_data));
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      nrn_q   <= '0;
      acc_q   <= '0;
      x_q     <= '{default: '0};
      h_q     <= '{default: '0};
      score_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nrn_q   <= nrn_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      h_q     <= h_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    bus.w1_addr = '0;
    bus.b1_addr = '0;
    bus.w2_addr = '0;
    if (state_q == StL1Mac) begin
      bus.b1_addr = nrn_q;
      if (cnt_q < 4'd9) bus.w1_addr = ({3'b000, nrn_q} * 5'd9) + {1'b0, cnt_q};
    end
    if (state_q == StL2Mac && cnt_q < 4'd3) bus.w2_addr = cnt_q[1:0];
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.valid_out = (state_q == StDone);
  assign bus.done      = (state_q == StDone);
  assign bus.score     = score_q;

endmodule
